// File: rtl/mm_request_bridge.sv
// mm_request_bridge: turns level-held read/write requests from a control
// sequencer into single Avalon-MM transfers. Supports waitrequest stalls,
// fixed-latency or readdatavalid read completion, and a transaction timeout
// that aborts the bus cycle and flags an error.
module mm_request_bridge #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int RD_LATENCY  = 1,
  parameter int USE_RDVALID = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_rq,
  input  logic              wr_rq,
  input  logic [ADDR_W-1:0] rd_adr,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              action_done,
  output logic              error,
  output logic [ADDR_W-1:0] mm_addr,
  output logic              mm_read,
  output logic              mm_write,
  output logic [DATA_W-1:0] mm_writedata,
  input  logic [DATA_W-1:0] mm_readdata,
  input  logic              mm_readdatavalid,
  input  logic              mm_waitrequest
);

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_WAIT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        lat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              rd_sample;
  logic              wr_accept;
  logic              active;

  assign mm_writedata = wdata_q;

  // Decode completion, abort and sampling conditions for the current cycle.
  always_comb begin
    tmo_hit   = 1'b0;
    rd_sample = 1'b0;
    active    = (state == READ) || (state == READ_WAIT) || (state == WRITE);
    wr_accept = (state == WRITE) && !mm_waitrequest;
    if (TIMEOUT > 0) begin
      tmo_hit = active && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    end
    if (state == READ_WAIT) begin
      if (USE_RDVALID != 0) begin
        rd_sample = mm_readdatavalid;
      end else begin
        rd_sample = (lat_cnt == 4'(RD_LATENCY));
      end
    end
  end

  // Next-state logic and the Avalon command outputs, which follow the state directly.
  always_comb begin
    state_nxt = state;
    mm_read   = 1'b0;
    mm_write  = 1'b0;
    mm_addr   = '0;
    case (state)
      IDLE: begin
        if (rd_rq) begin
          state_nxt = READ;
        end else if (wr_rq) begin
          state_nxt = WRITE;
        end
      end
      READ: begin
        mm_read = 1'b1;
        mm_addr = addr_q;
        if (tmo_hit) begin
          state_nxt = DONE;
        end else if (!mm_waitrequest) begin
          state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (rd_sample || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        mm_write = 1'b1;
        mm_addr  = addr_q;
        if (wr_accept || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!rd_rq && !wr_rq) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; async reset drops any bus command immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture, counters, read data and the completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt     <= '0;
      tmo_cnt     <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      action_done <= 1'b0;
      error       <= 1'b0;
    end else begin
      rd_valid    <= 1'b0;
      action_done <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        lat_cnt <= '0;
        if (rd_rq) begin
          addr_q <= rd_adr;
          error  <= 1'b0;
        end else if (wr_rq) begin
          addr_q  <= wr_adr;
          wdata_q <= wr_data;
          error   <= 1'b0;
        end
      end
      if (active && (tmo_cnt != TMO_W'(TIMEOUT))) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == READ && !mm_waitrequest) begin
        lat_cnt <= 4'd1;
      end else if (state == READ_WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (state != DONE && state_nxt == DONE) begin
        action_done <= 1'b1;
        error       <= !(rd_sample || wr_accept);
        if (rd_sample) begin
          rd_data  <= mm_readdata;
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule
